// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, FSM state type and op helpers
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRL = 4'b1010;
   localparam logic [3:0] ALU_SRA = 4'b1011;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/result bundle between ID/EX and the execute unit
interface alu_exec_unit_if #(
   parameter int DATA_W = 32
);
   logic              valid_i;
   logic              ready_o;
   logic [3:0]        ALUCtrl_i;
   logic [DATA_W-1:0] data1_i;
   logic [DATA_W-1:0] data2_i;
   logic              flush_i;
   logic [DATA_W-1:0] result_o;
   logic              zero_o;
   logic              valid_o;

   // upstream side: issues operations, observes results and stall
   modport master (
      output valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
      input  ready_o, result_o, zero_o, valid_o
   );

   // execute unit side
   modport slave (
      input  valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
      output ready_o, result_o, zero_o, valid_o
   );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU ops plus a single-bit shift step
module alu_core
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        shift_op,
   input  logic [DATA_W-1:0] shift_in,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] shift_out
);

   // single-cycle ops; unknown codes fall through to ADD
   always_comb begin
      result = a + b;
      case (op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default: result = a + b;
      endcase
   end

   // one bit of the iterative shifter
   always_comb begin
      shift_out = shift_in;
      case (shift_op)
         ALU_SLL: shift_out = {shift_in[DATA_W-2:0], 1'b0};
         ALU_SRL: shift_out = {1'b0, shift_in[DATA_W-1:1]};
         ALU_SRA: shift_out = {shift_in[DATA_W-1], shift_in[DATA_W-1:1]};
         default: shift_out = shift_in;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with iterative shifter (ALU_FAST_SHIFT_EN selects barrel shifter)
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = $clog2(DATA_W)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   alu_exec_unit_if.slave  bus
);

   logic [DATA_W-1:0]  result_q, result_d;
   logic               zero_q, zero_d;
   logic               valid_q, valid_d;
   logic [DATA_W-1:0]  core_result;
   logic [DATA_W-1:0]  step_out;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;

   assign shamt = bus.data2_i[SHAMT_W-1:0];

   assign bus.result_o = result_q;
   assign bus.zero_o   = zero_q;
   assign bus.valid_o  = valid_q;

`ifdef ALU_FAST_SHIFT_EN

   logic [DATA_W-1:0] barrel;

   assign bus.ready_o = !rst_i;
   assign accept      = bus.valid_i && !rst_i && !bus.flush_i;

   alu_core #(.DATA_W(DATA_W)) u_core (
      .op        (bus.ALUCtrl_i),
      .a         (bus.data1_i),
      .b         (bus.data2_i),
      .shift_op  (bus.ALUCtrl_i),
      .shift_in  (bus.data1_i),
      .result    (core_result),
      .shift_out (step_out)
   );

   // full-width shift in one cycle
   always_comb begin
      barrel = bus.data1_i;
      case (bus.ALUCtrl_i)
         ALU_SLL: barrel = bus.data1_i << shamt;
         ALU_SRL: barrel = bus.data1_i >> shamt;
         ALU_SRA: barrel = DATA_W'($signed(bus.data1_i) >>> shamt);
         default: barrel = bus.data1_i;
      endcase
   end

   // every accepted op completes in one cycle
   always_comb begin
      result_d = result_q;
      zero_d   = zero_q;
      valid_d  = 1'b0;
      if (accept) begin
         result_d = is_shift_op(bus.ALUCtrl_i) ? barrel : core_result;
         zero_d   = (result_d == '0);
         valid_d  = 1'b1;
      end
   end

   // output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         valid_q  <= valid_d;
      end
   end

`else

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  acc_q, acc_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [3:0]         op_q, op_d;

   assign bus.ready_o = (state_q == IDLE) && !rst_i;
   assign accept      = bus.valid_i && bus.ready_o && !bus.flush_i;

   alu_core #(.DATA_W(DATA_W)) u_core (
      .op        (bus.ALUCtrl_i),
      .a         (bus.data1_i),
      .b         (bus.data2_i),
      .shift_op  (op_q),
      .shift_in  (acc_q),
      .result    (core_result),
      .shift_out (step_out)
   );

   // next state: accept in IDLE, one shift bit per SHIFT cycle, flush aborts
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      result_d = result_q;
      zero_d   = zero_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!is_shift_op(bus.ALUCtrl_i)) begin
                  result_d = core_result;
                  zero_d   = (core_result == '0);
                  valid_d  = 1'b1;
               end else if (shamt == '0) begin
                  result_d = bus.data1_i;
                  zero_d   = (bus.data1_i == '0);
                  valid_d  = 1'b1;
               end else begin
                  acc_d   = bus.data1_i;
                  cnt_d   = shamt;
                  op_d    = bus.ALUCtrl_i;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (bus.flush_i) begin
               state_d = IDLE;
            end else begin
               acc_d = step_out;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == SHAMT_W'(1)) begin
                  result_d = step_out;
                  zero_d   = (step_out == '0);
                  valid_d  = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, shifter and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         valid_q  <= valid_d;
      end
   end

`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   alu_exec_unit_if #(.DATA_W(32)) bus ();

   alu_exec_unit #(.DATA_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.valid_i   = 1'b1;
      bus.ALUCtrl_i = op;
      bus.data1_i   = a;
      bus.data2_i   = b;
   endtask

   task automatic idle_inputs();
      bus.valid_i   = 1'b0;
      bus.flush_i   = 1'b0;
      bus.ALUCtrl_i = 4'b0000;
      bus.data1_i   = '0;
      bus.data2_i   = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o); end
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
      checks++; if (bus.result_o !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
      checks++; if (bus.zero_o !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", bus.zero_o); end
      rst = 1'b0;
      tick();
      checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", bus.ready_o); end
      // give result_o a nonzero value, then reset in the middle of a shift
      issue(ALU_ADD, 32'd7, 32'd1);
      tick();
      checks++; if (bus.result_o !== 32'd8) begin failures++; $display("FAIL pre_add got=%h exp=8", bus.result_o); end
      issue(ALU_SLL, 32'd3, 32'd10);
      tick();
      idle_inputs();
      checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL shift_busy got=%b exp=0", bus.ready_o); end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready%0d got=%b exp=0", i, bus.ready_o); end
         tick();
         checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid%0d got=%b exp=0", i, bus.valid_o); end
      end
      checks++; if (bus.result_o !== 32'h0) begin failures++; $display("FAIL midrst_result got=%h exp=0", bus.result_o); end
      checks++; if (bus.zero_o !== 1'b0) begin failures++; $display("FAIL midrst_zero got=%b exp=0", bus.zero_o); end
      rst = 1'b0;
      tick();
      checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", bus.ready_o); end
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL midrst_novalid got=%b exp=0", bus.valid_o); end
   endtask

   task automatic test_back_to_back();
      issue(ALU_SUB, 32'd5, 32'd5);
      tick();
      issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
      checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL sub_valid got=%b exp=1", bus.valid_o); end
      checks++; if (bus.result_o !== 32'h0) begin failures++; $display("FAIL sub_result got=%h exp=0", bus.result_o); end
      checks++; if (bus.zero_o !== 1'b1) begin failures++; $display("FAIL sub_zero got=%b exp=1", bus.zero_o); end
      tick();
      idle_inputs();
      checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", bus.valid_o); end
      checks++; if (bus.result_o !== 32'h8000_0000) begin failures++; $display("FAIL add_wrap got=%h exp=80000000", bus.result_o); end
      checks++; if (bus.zero_o !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", bus.zero_o); end
      tick();
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL b2b_pulse got=%b exp=0", bus.valid_o); end
      checks++; if (bus.result_o !== 32'h8000_0000) begin failures++; $display("FAIL b2b_hold got=%h exp=80000000", bus.result_o); end
   endtask

   task automatic test_logic_slt();
      logic [3:0]  ops [5]  = '{ALU_SLT, ALU_SLT, ALU_AND, ALU_OR, ALU_XOR};
      logic [31:0] as  [5]  = '{32'hFFFF_FFFF, 32'd1, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_00FF};
      logic [31:0] bs  [5]  = '{32'd1, 32'hFFFF_FFFF, 32'h0000_FF00, 32'h0000_0F0F, 32'h0000_000F};
      logic [31:0] exp [5]  = '{32'd1, 32'd0, 32'h0000_F000, 32'h0000_FFFF, 32'h0000_00F0};
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], as[i], bs[i]);
         tick();
         idle_inputs();
         checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL op%0d_valid got=%b exp=1", i, bus.valid_o); end
         checks++; if (bus.result_o !== exp[i]) begin failures++; $display("FAIL op%0d_result got=%h exp=%h", i, bus.result_o, exp[i]); end
         checks++; if (bus.zero_o !== (exp[i] == 32'h0)) begin failures++; $display("FAIL op%0d_zero got=%b exp=%b", i, bus.zero_o, exp[i] == 32'h0); end
      end
   endtask

   task automatic test_shift();
      int cyc;
      issue(ALU_SRA, 32'h8000_0000, 32'd4);
      tick();
      idle_inputs();
      for (int i = 1; i <= 4; i++) begin
         checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL sra_ready_c%0d got=%b exp=0", i, bus.ready_o); end
         checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL sra_early_c%0d got=%b exp=0", i, bus.valid_o); end
         tick();
      end
      checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL sra_valid got=%b exp=1", bus.valid_o); end
      checks++; if (bus.result_o !== 32'hF800_0000) begin failures++; $display("FAIL sra_result got=%h exp=f8000000", bus.result_o); end
      checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL sra_ready_done got=%b exp=1", bus.ready_o); end

      issue(ALU_SLL, 32'd1, 32'd31);
      tick();
      idle_inputs();
      cyc = 1;
      while (bus.valid_o !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      checks++; if (cyc !== 32) begin failures++; $display("FAIL sll31_latency got=%0d exp=32", cyc); end
      checks++; if (bus.result_o !== 32'h8000_0000) begin failures++; $display("FAIL sll31_result got=%h exp=80000000", bus.result_o); end

      issue(ALU_SRL, 32'h8000_0000, 32'd1);
      tick();
      idle_inputs();
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL srl1_early got=%b exp=0", bus.valid_o); end
      tick();
      checks++; if (bus.result_o !== 32'h4000_0000 || bus.valid_o !== 1'b1) begin failures++; $display("FAIL srl1_result got=%h/%b exp=40000000/1", bus.result_o, bus.valid_o); end

      issue(ALU_SRL, 32'hDEAD_BEEF, 32'd0);
      tick();
      idle_inputs();
      checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL srl0 got=%h/%b exp=deadbeef/1", bus.result_o, bus.valid_o); end

      issue(4'b0111, 32'd2, 32'd3);
      tick();
      idle_inputs();
      checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd5) begin failures++; $display("FAIL unknown_op got=%h/%b exp=5/1", bus.result_o, bus.valid_o); end
   endtask

   task automatic test_flush();
      issue(ALU_ADD, 32'h1234, 32'h0);
      tick();
      idle_inputs();
      checks++; if (bus.result_o !== 32'h1234) begin failures++; $display("FAIL flush_prep got=%h exp=1234", bus.result_o); end
      issue(ALU_SLL, 32'd1, 32'd10);
      tick();
      idle_inputs();
      tick();
      tick();
      checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.ready_o); end
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", bus.ready_o); end
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.valid_o); end
      checks++; if (bus.result_o !== 32'h1234) begin failures++; $display("FAIL flush_hold got=%h exp=1234", bus.result_o); end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL flush_late%0d got=%b exp=0", i, bus.valid_o); end
      end
      issue(ALU_ADD, 32'd1, 32'd1);
      bus.flush_i = 1'b1;
      tick();
      idle_inputs();
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL idle_flush_valid got=%b exp=0", bus.valid_o); end
      checks++; if (bus.result_o !== 32'h1234) begin failures++; $display("FAIL idle_flush_hold got=%h exp=1234", bus.result_o); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      idle_inputs();
      test_reset();
      test_back_to_back();
      test_logic_slt();
      test_shift();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic unit directly downstream of the ALU control decoder: consumes the 4-bit ALU control code plus two operands and produces a registered result and zero flag. Logic/arithmetic ops complete in one cycle; shifts run on an iterative one-bit-per-cycle shifter, during which the unit deasserts ready so the hazard unit stalls IF/ID/EX. A flush input aborts in-flight work on branch redirect.

## Interface
- DATA_W, 32, operand/result width (power of two, ≥ 8)
- SHAMT_W, $clog2(DATA_W), shift-amount width taken from data2_i LSBs
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  operation request this cycle
- ready_o  out  1  unit can accept; also drives the hazard unit stall (stall = ~ready_o)
- ALUCtrl_i  in  4  op code: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLT 1000, SLL 1001, SRL 1010, SRA 1011
- data1_i  in  DATA_W  operand A / shift source
- data2_i  in  DATA_W  operand B / shift amount in [SHAMT_W-1:0]
- flush_i  in  1  abort current/incoming operation
- result_o  out  DATA_W  registered result
- zero_o  out  1  registered (result == 0)
- valid_o  out  1  one-cycle pulse: result_o/zero_o updated this cycle

## Operation
- States: IDLE, SHIFT. ready_o = (state == IDLE) && !rst_i.
- Accept = valid_i && ready_o && !flush_i.
- IDLE, accept, non-shift op: compute, register result_o/zero_o, pulse valid_o next cycle; stay IDLE (back-to-back accepts allowed every cycle).
- IDLE, accept, shift op, shamt == 0: result_o = data1_i, latency 1, stay IDLE.
- IDLE, accept, shift op, shamt ≠ 0: load acc = data1_i, cnt = shamt, latch op; go SHIFT.
- SHIFT: each cycle acc shifted one bit (SLL: zero-fill left; SRL: zero-fill right; SRA: replicate MSB), cnt decrements. When cnt == 1 the shifted value goes to result_o/zero_o, valid_o pulses, state → IDLE.
- SLT: signed two's-complement compare, result 1 or 0 zero-extended. ADD/SUB wrap modulo 2^DATA_W, no overflow flag.
- Unknown ALUCtrl_i codes execute as ADD.
- flush_i: in SHIFT → IDLE next cycle, no valid_o, result_o unchanged; in IDLE blocks acceptance that cycle (flush wins over simultaneous valid_i).
- valid_i while ready_o low is ignored; upstream must hold it (stall guarantees this).
- result_o/zero_o hold their last value when valid_o is low.

## Timing
- Reset values: state IDLE, result_o 0, zero_o 0, valid_o 0, acc 0, cnt 0; ready_o 0 while rst_i high, 1 the cycle after release.
- Reset mid-SHIFT: abort, no valid_o, outputs to reset values.
- Latency accept→valid_o: 1 cycle for non-shift ops and shamt 0; shamt+1 cycles for shifts (max DATA_W for shamt DATA_W-1).
- ready_o low for exactly shamt cycles after a shift accept; next accept possible in the same cycle valid_o pulses.
- No output backpressure: consumer must sample on valid_o.

## Configuration
- ALU_FAST_SHIFT_EN defined: shifts use a single-cycle barrel shifter, latency 1, SHIFT state and counter removed, ready_o = !rst_i.
- Undefined (default): iterative shifter as above.

## Structure
- Package alu_pkg: the nine ALUCtrl localparams (shared with the control decoder), state enum.
- Sub-module alu_core: purely combinational ADD/SUB/AND/OR/XOR/SLT and single-bit shift step; alu_exec_unit holds FSM, counter, acc and output registers.

## Test plan
- Reset held 3 cycles mid-shift → result_o 0, zero_o 0, valid_o 0, ready_o 0 during reset, 1 after.
- SUB 5−5 then ADD 0x7FFFFFFF+1 back-to-back → valid_o two consecutive cycles, results 0 (zero_o 1) then 0x80000000 (zero_o 0).
- SLT −1 vs 1 → 1; SLT 1 vs −1 → 0; latency 1.
- SRA 0x80000000 by 4 → ready_o low 4 cycles, valid_o on 5th cycle, result 0xF8000000; SLL 1 by 31 → 0x80000000 at cycle 32.
- SRL by 0 → data1_i returned in 1 cycle; unknown code 0111 with 2,3 → 5.
- SLL by 10, flush_i on 3rd SHIFT cycle → no valid_o, ready_o 1 next cycle, result_o keeps prior value; flush_i with valid_i in IDLE → dropped.
